// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: four requesters share one binary-to-Gray converter.
// Round-robin grant, one-entry registered output with valid/ready drain.
module gray_conv_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] bin0,
    input  logic [W-1:0] bin1,
    input  logic [W-1:0] bin2,
    input  logic [W-1:0] bin3,
    output logic [3:0]   ack,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gray,
    output logic [1:0]   out_id,
    input  logic         cnt_clr,
    output logic [7:0]   conv_count
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e       state_q;
    logic [1:0]   ptr_q;
    logic [W-1:0] gray_q;
    logic [1:0]   id_q;
    logic [7:0]   cnt_q;

    logic         accept;
    logic         gnt_v;
    logic [1:0]   gnt_d;
    logic [1:0]   idx;
    logic [W-1:0] bin_sel;
    logic [W-1:0] gray_d;
    logic         xfer;
    logic         hs;

    // Round-robin search starting at ptr_q; first set request wins.
    always_comb begin
        gnt_v = 1'b0;
        gnt_d = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!gnt_v && req[idx]) begin
                gnt_v = 1'b1;
                gnt_d = idx;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        bin_sel = bin0;
        unique case (gnt_d)
            2'd0: bin_sel = bin0;
            2'd1: bin_sel = bin1;
            2'd2: bin_sel = bin2;
            2'd3: bin_sel = bin3;
            default: bin_sel = bin0;
        endcase
    end

    assign gray_d = bin_sel ^ (bin_sel >> 1);
    assign accept = (state_q == EMPTY) || out_ready;
    assign xfer   = accept && gnt_v;
    assign hs     = (state_q == FULL) && out_ready;

    // Ack is suppressed during reset so no requester sees a phantom grant.
    assign ack = (rst_n && xfer) ? (4'b0001 << gnt_d) : 4'b0000;

    // Output slot control: load on transfer, empty on drain without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd0;
            gray_q  <= '0;
            id_q    <= 2'd0;
        end else begin
            if (xfer) begin
                gray_q <= gray_d;
                id_q   <= gnt_d;
                ptr_q  <= gnt_d + 2'd1;
            end
            unique case (state_q)
                EMPTY: if (xfer) state_q <= FULL;
                FULL:  if (!xfer && out_ready) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Saturating handshake counter; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (cnt_clr) begin
            cnt_q <= 8'd0;
        end else if (hs && cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_gray   = gray_q;
    assign out_id     = id_q;
    assign conv_count = cnt_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed steps with a result scoreboard.
// Expected results are queued at transfer and popped at handshake.
module tb_gray_conv_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] bin0, bin1, bin2, bin3;
    logic [3:0]   ack;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gray;
    logic [1:0]   out_id;
    logic         cnt_clr;
    logic [7:0]   conv_count;

    int errors = 0;
    int checks = 0;

    logic [W+1:0] sb[$];
    logic         valid_m;
    logic [7:0]   cnt_m;
    logic [1:0]   ptr_m;

    logic [3:0]   gtbl[16];

    gray_conv_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .bin0       (bin0),
        .bin1       (bin1),
        .bin2       (bin2),
        .bin3       (bin3),
        .ack        (ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gray   (out_gray),
        .out_id     (out_id),
        .cnt_clr    (cnt_clr),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] gray_m(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int k = 0; k < W - 1; k++) g[k] = b[k+1] ^ b[k];
        return g;
    endfunction

    function automatic logic [W-1:0] bin_m(input logic [1:0] g);
        case (g)
            2'd0: return bin0;
            2'd1: return bin1;
            2'd2: return bin2;
            default: return bin3;
        endcase
    endfunction

    task automatic model_reset();
        sb.delete();
        valid_m = 1'b0;
        cnt_m   = 8'd0;
        ptr_m   = 2'd0;
    endtask

    // One clock: entered and left at a falling edge with inputs set.
    task automatic cycle();
        logic       acc, gv, hs;
        logic [1:0] g, k;
        logic [3:0] eack;
        #1;
        acc = !valid_m || out_ready;
        gv  = 1'b0;
        g   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            k = ptr_m + 2'(i);
            if (!gv && req[k]) begin
                gv = 1'b1;
                g  = k;
            end
        end
        eack = (acc && gv) ? (4'b0001 << g) : 4'b0000;
        chk("ack", 32'(ack), 32'(eack));
        chk("out_valid", 32'(out_valid), 32'(valid_m));
        chk("conv_count", 32'(conv_count), 32'(cnt_m));
        if (valid_m && sb.size() > 0) begin
            chk("out_gray", 32'(out_gray), 32'(sb[0][W-1:0]));
            chk("out_id", 32'(out_id), 32'(sb[0][W+1:W]));
        end
        hs = valid_m && out_ready;
        @(posedge clk);
        if (hs) void'(sb.pop_front());
        if (acc && gv) begin
            sb.push_back({g, gray_m(bin_m(g))});
            ptr_m = g + 2'd1;
        end
        valid_m = (acc && gv) || (valid_m && !hs);
        if (cnt_clr) cnt_m = 8'd0;
        else if (hs && cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] order[5];
        gtbl = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        req = 4'b1111; out_ready = 1'b1; cnt_clr = 1'b0;
        bin0 = 4'h3; bin1 = 4'h6; bin2 = 4'h9; bin3 = 4'hC;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_gray", 32'(out_gray), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        chk("rst_count", 32'(conv_count), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 1.
        req = 4'b0010; bin1 = 4'b0110;
        #1;
        chk("single_ack", 32'(ack), 32'b0010);
        cycle();
        req = 4'b0000;
        chk("single_gray", 32'(out_gray), 32'b0101);
        chk("single_id", 32'(out_id), 32'd1);
        cycle();
        chk("single_count", 32'(conv_count), 32'd1);

        // Round-robin fairness from reset.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            bin0 = 4'(i); bin1 = 4'(i + 4);
            bin2 = 4'(i + 8); bin3 = 4'(i + 12);
            #1;
            chk("rr_order", 32'(ack), 32'(order[i]));
            cycle();
        end
        req = 4'b0000;
        cycle();

        // Backpressure with drain-and-refill.
        req = 4'b0001; bin0 = 4'hA; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0; bin0 = 4'h5;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ack", 32'(ack), 32'd0);
            cycle();
        end
        chk("bp_hold", 32'(out_gray), 32'(gtbl[10]));
        out_ready = 1'b1;
        cycle();
        chk("bp_refill_valid", 32'(out_valid), 32'd1);
        chk("bp_refill_gray", 32'(out_gray), 32'(gtbl[5]));
        req = 4'b0000;
        cycle();
        cycle();

        // Exhaustive conversion via requester 3.
        req = 4'b1000;
        for (int v = 0; v < 16; v++) begin
            bin3 = 4'(v);
            cycle();
            chk("exh_gray", 32'(out_gray), 32'(gtbl[v]));
        end
        req = 4'b0000;
        cycle();

        // Saturation then clear during a handshake.
        req = 4'b0001; bin0 = 4'h7;
        for (int i = 0; i < 262; i++) begin
            bin0 = 4'(i);
            cycle();
        end
        chk("sat_count", 32'(conv_count), 32'd255);
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        chk("clr_count", 32'(conv_count), 32'd0);

        // Reset while holding a result from requester 2.
        req = 4'b0100; bin2 = 4'hE;
        cycle();
        out_ready = 1'b0;
        cycle();
        chk("mid_id", 32'(out_id), 32'd2);
        chk("mid_count", 32'(conv_count), 32'd1);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_gray", 32'(out_gray), 32'd0);
        chk("mid_rst_count", 32'(conv_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111; out_ready = 1'b1;
        #1;
        chk("post_rst_ack", 32'(ack), 32'b0001);
        cycle();
        req = 4'b0000;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter W, default 4, binary/Gray data width; legal range 2..16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester conversion request; bit i belongs to requester i.
REQ-005 bin0, bin1, bin2, bin3  input  W each  binary operand of requester i; valid only while req[i]=1.
REQ-006 ack  output  4  per-requester accept; one-hot or zero; combinational.
REQ-007 out_valid  output  1  out_gray/out_id hold a converted result.
REQ-008 out_ready  input  1  downstream consumer accepts the result.
REQ-009 out_gray  output  W  Gray code of the granted operand; registered.
REQ-010 out_id  output  2  index of the requester whose result is presented; registered.
REQ-011 cnt_clr  input  1  synchronous clear of conv_count.
REQ-012 conv_count  output  8  number of completed output handshakes, saturating.

Function
REQ-013 accept SHALL equal (!out_valid || out_ready); a new grant SHALL be issued only in a cycle where accept=1 and req!=0.
REQ-014 Arbitration SHALL be round-robin: search order starts at ptr, then ptr+1, ptr+2, ptr+3 (mod 4); the first set req bit wins.
REQ-015 ack[g] SHALL be 1 in the grant cycle only; all other ack bits SHALL be 0; ack SHALL be 0 when accept=0 or req=0.
REQ-016 Transfer SHALL occur at the clock edge ending a cycle with req[g]=1 and ack[g]=1; a requester holding req high SHALL be able to present new data the next cycle.
REQ-017 On transfer: out_gray <= gray(bin_g), out_id <= g, out_valid <= 1, ptr <= g+1 (mod 4).
REQ-018 gray(B): G[W-1]=B[W-1]; G[k]=B[k+1] XOR B[k] for k=W-2..0.
REQ-019 Latency SHALL be 1 cycle from transfer edge to out_valid=1; throughput SHALL be 1 result per cycle while out_ready=1.
REQ-020 Output handshake SHALL complete at an edge where out_valid=1 and out_ready=1; out_valid SHALL clear at that edge unless a new transfer happens the same edge (drain-and-refill; out_valid stays 1).
REQ-021 While out_valid=1 and out_ready=0, out_gray and out_id SHALL hold stable, ack SHALL be 0, and ptr SHALL hold.
REQ-022 Control states: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on transfer; FULL->EMPTY on handshake without transfer; FULL->FULL on stall or drain-and-refill.
REQ-023 conv_count SHALL increment by 1 on each output handshake and saturate at 255.
REQ-024 cnt_clr=1 SHALL set conv_count to 0 at the next edge; cnt_clr SHALL take priority over a simultaneous increment.
REQ-025 A requester dropping req before ack SHALL be ignored without side effects.

Reset
REQ-026 rst_n=0 SHALL force immediately: out_valid=0, out_gray=0, out_id=0, ptr=0, conv_count=0; ack SHALL be 0 while rst_n=0.
REQ-027 Reset asserted while FULL SHALL discard the held result; no handshake SHALL be counted.
REQ-028 After rst_n deasserts, the first grant SHALL use search order 0,1,2,3.

Verification
REQ-029 Single request: W=4, req=0010, bin1=0110, out_ready=1 -> ack=0010 in the same cycle; next cycle out_valid=1, out_gray=0101, out_id=1; conv_count=1 after the handshake.
REQ-030 Round-robin fairness: req=1111 held, out_ready=1 from reset -> grant order 0,1,2,3,0; each ack is one-hot, and there is one result per cycle.
REQ-031 Backpressure: FULL with out_ready=0 for 3 cycles and req=0001 -> ack=0000, outputs stable, ptr unchanged; out_ready=1 -> drain-and-refill in one cycle, out_valid stays 1.
REQ-032 Exhaustive conversion: requester 3 presents bin 0..15 sequentially -> out_gray sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.
REQ-033 Saturation and clear: 260 handshakes -> conv_count=255; cnt_clr together with a handshake -> conv_count=0.
REQ-034 Reset mid-operation: rst_n=0 while FULL with out_id=2 -> out_valid=0, out_gray=0, conv_count=0 at once; after release with req=1111 -> first grant to requester 0.
